// File: rtl/cpu_pkg.sv
// Shared fetch-path types and default widths for the PC fetch unit.
package cpu_pkg;

  localparam int          CPU_ADDR_W   = 16;
  localparam int          CPU_DATA_W   = 16;
  localparam logic [15:0] CPU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit handshake bundle: control-FSM side (master) and fetch unit (slave).
// The return-stack signals exist only when RET_STACK_EN is defined.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_pkg::CPU_DATA_W
);

  logic              fetch_req;
  logic              stall;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_target;
  logic              bram_rd_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ack;
  logic [ADDR_W-1:0] pc;
`ifdef RET_STACK_EN
  logic              call_en;
  logic              ret_en;
  logic              ras_err;
`endif

  modport master (
    output fetch_req, stall, ld_en, ld_target, bram_rdata, instr_ack,
`ifdef RET_STACK_EN
    output call_en, ret_en,
    input  ras_err,
`endif
    input  bram_rd_en, bram_addr, instr, instr_valid, pc
  );

  modport slave (
    input  fetch_req, stall, ld_en, ld_target, bram_rdata, instr_ack,
`ifdef RET_STACK_EN
    input  call_en, ret_en,
    output ras_err,
`endif
    output bram_rd_en, bram_addr, instr, instr_valid, pc
  );

endinterface

// File: rtl/ret_addr_stack.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr is the next free slot; after DEPTH pushes it wraps onto the oldest entry
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  // Stack storage, pointer and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (!o_full) begin
        r_cnt <= r_cnt + (PTR_W+1)'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus single-outstanding BRAM instruction fetch with valid/ack hand-off.
// Define RET_STACK_EN to add call/return redirects through a return-address stack.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC),
  parameter int                BRAM_LAT = 1
`ifdef RET_STACK_EN
  , parameter int              RAS_DEPTH = 4
`endif
) (
  input logic            clk,
  input logic            reset_n,
  pc_fetch_unit_if.slave bus
);

  localparam int CNT_W = $clog2(BRAM_LAT + 1);

  fetch_state_t      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_bram_addr;
  logic              r_bram_rd_en;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_issue_pc;
  logic [ADDR_W-1:0] w_ack_pc;
  logic              w_issue;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_issue    = (r_state == IDLE) && bus.fetch_req && !bus.stall;
  assign w_issue_pc = bus.ld_en ? bus.ld_target : r_pc;

  assign bus.bram_rd_en  = r_bram_rd_en;
  assign bus.bram_addr   = r_bram_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc          = r_pc;

`ifdef RET_STACK_EN
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_ras_full;
  logic              w_ras_empty;
  logic [ADDR_W-1:0] w_ras_top;
  logic              r_ras_err;

  // Stack is only touched when the held instruction is accepted; ret beats call
  assign w_accept = (r_state == HOLD) && bus.instr_ack;
  assign w_pop    = w_accept && bus.ret_en;
  assign w_push   = w_accept && bus.call_en && !bus.ret_en;
  assign bus.ras_err = r_ras_err;

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_ras_top),
    .o_full      (w_ras_full),
    .o_empty     (w_ras_empty)
  );

  // One-cycle error pulse on push-when-full or pop-when-empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ras_err <= 1'b0;
    end else begin
      r_ras_err <= (w_pop && w_ras_empty) || (w_push && w_ras_full);
    end
  end
`endif

  // Next PC taken when the consumer acknowledges the held instruction
  always_comb begin
    w_ack_pc = w_pc_inc;
`ifdef RET_STACK_EN
    if (bus.ret_en) begin
      w_ack_pc = w_ras_empty ? w_pc_inc : w_ras_top;
    end else if (bus.call_en || bus.ld_en) begin
      w_ack_pc = bus.ld_target;
    end else begin
      w_ack_pc = w_pc_inc;
    end
`else
    if (bus.ld_en) begin
      w_ack_pc = bus.ld_target;
    end else begin
      w_ack_pc = w_pc_inc;
    end
`endif
  end

  // Fetch FSM: issue, wait out BRAM latency, hold until acknowledged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_pc          <= RESET_PC;
      r_bram_addr   <= RESET_PC;
      r_bram_rd_en  <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_bram_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ld_en) begin
            r_pc <= bus.ld_target;
          end
          if (w_issue) begin
            r_bram_rd_en <= 1'b1;
            r_bram_addr  <= w_issue_pc;
            r_cnt        <= CNT_W'(BRAM_LAT);
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          // A redirect squashes the in-flight read; its late data is never captured
          if (bus.ld_en) begin
            r_pc    <= bus.ld_target;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_instr       <= bus.bram_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.instr_ack) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_ack_pc;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; BRAM model returns addr ^ 16'h5A5A one cycle after the strobe.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.BRAM_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Latency-1 BRAM: data for the strobed address appears after the next edge
  always @(posedge clk) begin
    if (bus.bram_rd_en) bus.bram_rdata <= bus.bram_addr ^ 16'h5A5A;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input logic [15:0] exp_addr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.bram_rd_en && n < 10);
    check({tag, "_strobe"}, bus.bram_rd_en, 1);
    check({tag, "_addr"}, bus.bram_addr, exp_addr);
  endtask

  task automatic wait_instr(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_instr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.instr_valid && n < 10);
    check({tag, "_lat"}, n, 2);
    check({tag, "_instr"}, bus.instr, exp_instr);
    check({tag, "_pc"}, bus.pc, exp_pc);
  endtask

  task automatic ack(input string tag, input logic ld, input logic [15:0] tgt);
    bus.ld_en     = ld;
    bus.ld_target = tgt;
    bus.instr_ack = 1'b1;
    tick();
    bus.instr_ack = 1'b0;
    bus.ld_en     = 1'b0;
    check({tag, "_vld_drop"}, bus.instr_valid, 0);
  endtask

`ifdef RET_STACK_EN
  task automatic ack_ras(input string tag, input logic call, input logic ret,
                         input logic [15:0] tgt, input logic exp_err);
    bus.call_en   = call;
    bus.ret_en    = ret;
    bus.ld_target = tgt;
    bus.instr_ack = 1'b1;
    tick();
    bus.instr_ack = 1'b0;
    bus.call_en   = 1'b0;
    bus.ret_en    = 1'b0;
    check({tag, "_raserr"}, bus.ras_err, exp_err);
  endtask
`endif

  initial begin
    bus.fetch_req = 1'b1;
    bus.stall     = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_target = 16'h0000;
    bus.instr_ack = 1'b0;
`ifdef RET_STACK_EN
    bus.call_en   = 1'b0;
    bus.ret_en    = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_addr", bus.bram_addr, 16'h0000);
    check("rst_rden", bus.bram_rd_en, 0);
    check("rst_vld", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 16'h0000);
    reset_n = 1'b1;

    // 1/2: first fetch straight out of reset, then sequential fetches
    wait_strobe("f0", 16'h0000);
    tick();
    check("f0_pulse", bus.bram_rd_en, 0);
    check("f0_novld", bus.instr_valid, 0);
    tick();
    check("f0_vld", bus.instr_valid, 1);
    check("f0_instr", bus.instr, 16'h5A5A);
    check("f0_pc", bus.pc, 16'h0000);
    ack("f0", 1'b0, 16'h0000);
    wait_strobe("f1", 16'h0001);
    wait_instr("f1", 16'h0001, 16'h5A5B);
    ack("f1", 1'b0, 16'h0000);
    wait_strobe("f2", 16'h0002);
    wait_instr("f2", 16'h0002, 16'h5A58);

    // 3: jump on ack
    ack("j40", 1'b1, 16'h0040);
    wait_strobe("j40", 16'h0040);
    wait_instr("j40", 16'h0040, 16'h5A1A);
    ack("f40", 1'b0, 16'h0000);

    // stall holds off issue from IDLE
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rden", bus.bram_rd_en, 0);
    end
    bus.stall = 1'b0;

    // 4: redirect while waiting on BRAM squashes the fetch
    wait_strobe("sq", 16'h0041);
    bus.ld_en     = 1'b1;
    bus.ld_target = 16'h0080;
    tick();
    bus.ld_en = 1'b0;
    check("sq_novld", bus.instr_valid, 0);
    check("sq_pc", bus.pc, 16'h0080);
    tick();
    check("sq_restrobe", bus.bram_rd_en, 1);
    check("sq_readdr", bus.bram_addr, 16'h0080);
    check("sq_novld2", bus.instr_valid, 0);
    wait_instr("sq", 16'h0080, 16'h5ADA);

    // 5: wrap at the top of the address space, and holding without ack
    ack("jff", 1'b1, 16'hFFFF);
    wait_strobe("ff", 16'hFFFF);
    wait_instr("ff", 16'hFFFF, 16'hA5A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_vld", bus.instr_valid, 1);
      check("hold_instr", bus.instr, 16'hA5A5);
      check("hold_pc", bus.pc, 16'hFFFF);
      check("hold_rden", bus.bram_rd_en, 0);
    end
    ack("wrap", 1'b0, 16'h0000);
    check("wrap_pc", bus.pc, 16'h0000);
    wait_strobe("wrap", 16'h0000);
    wait_instr("wrap", 16'h0000, 16'h5A5A);

`ifdef RET_STACK_EN
    // 6: five calls overflow a 4-deep stack, five returns underflow it
    ack("j10", 1'b1, 16'h0010);
    wait_strobe("c0", 16'h0010);
    wait_instr("c0", 16'h0010, 16'h5A4A);
    for (int i = 0; i < 5; i++) begin
      ack_ras("call", 1'b1, 1'b0, 16'h0100, (i == 4));
      wait_strobe("call", 16'h0100);
      wait_instr("call", 16'h0100, 16'h5B5A);
    end
    for (int i = 0; i < 4; i++) begin
      ack_ras("ret", 1'b0, 1'b1, 16'h0000, 1'b0);
      wait_strobe("ret", 16'h0101);
      wait_instr("ret", 16'h0101, 16'h5B5B);
    end
    ack_ras("ret_uf", 1'b0, 1'b1, 16'h0000, 1'b1);
    wait_strobe("ret_uf", 16'h0102);
    check("ret_uf_pulse", bus.ras_err, 0);
    wait_instr("ret_uf", 16'h0102, 16'h5B58);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
